// File: rtl/fc_layer_engine.sv
// Int8 fully-connected layer engine: LANES-wide MAC over IN_LEN activations per output,
// then requantise to int8 (ties round down, saturate both ends, optional ReLU) and write out.
module fc_layer_engine #(
  parameter int IN_LEN  = 1600,
  parameter int OUT_LEN = 12,
  parameter int LANES   = 16,
  parameter int ACT_AW  = 12,
  parameter int W_AW    = 15,
  parameter int QP_AW   = 9,
  parameter int W_BASE  = 2664,
  parameter int QP_BASE = 108,
  parameter int OUT_ZP  = -128,
  localparam int OW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     act_en,
  output logic [ACT_AW-1:0]        act_addr,
  input  logic signed [7:0]        act_data,
  output logic                     w_en,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [7:0]        w_data,
  output logic                     qp_en,
  output logic [QP_AW-1:0]         qp_addr,
  input  logic signed [31:0]       qp_data,
  output logic                     res_we,
  output logic [OW-1:0]            res_addr,
  output logic signed [7:0]        res_data
);
  localparam int CHUNKS = (IN_LEN + LANES - 1) / LANES;
  localparam int KW     = $clog2(LANES + 3);
  localparam int CW     = $clog2(CHUNKS + 1);
  localparam int OCW    = $clog2(OUT_LEN + 1);
  localparam logic [KW-1:0]  K_LAST = KW'(LANES - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(CHUNKS - 1);
  localparam logic [OCW-1:0] O_LAST = OCW'(OUT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_MUL, S_ACC, S_QP, S_QDRAIN, S_REQ, S_WR, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CW-1:0]      c_q, c_d;
  logic [OCW-1:0]     o_q, o_d;
  logic               acc_clr, relu_q, en_q, in_rng;
  logic signed [7:0]  a_q [LANES];
  logic signed [7:0]  wt_q [LANES];
  logic signed [15:0] prod_q [LANES];
  logic signed [31:0] acc_q, z_q, b_q, sum, s;
  logic [31:0]        m_q, idx;
  logic signed [63:0] p;
  logic signed [31:0] hi;
  logic               rnd;
  logic signed [33:0] r, lo;
  logic signed [7:0]  res_q, res_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    o_d     = o_q;
    acc_clr = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        k_d     = '0;
        c_d     = '0;
        o_d     = '0;
        acc_clr = 1'b1;
      end
      S_FETCH: if (k_q == K_LAST) begin
        state_d = S_DRAIN;
        k_d     = '0;
      end else k_d = k_q + KW'(1);
      S_DRAIN: state_d = S_MUL;
      S_MUL:   state_d = S_ACC;
      S_ACC: if (c_q == C_LAST) begin
        state_d = S_QP;
        c_d     = '0;
      end else begin
        state_d = S_FETCH;
        c_d     = c_q + CW'(1);
      end
      S_QP: if (k_q == KW'(2)) begin
        state_d = S_QDRAIN;
        k_d     = '0;
      end else k_d = k_q + KW'(1);
      S_QDRAIN: state_d = S_REQ;
      S_REQ:    state_d = S_WR;
      S_WR: if (o_q == O_LAST) state_d = S_DONE;
      else begin
        state_d = S_FETCH;
        o_d     = o_q + OCW'(1);
        acc_clr = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      o_q     <= o_d;
    end
  end

  assign idx    = 32'(c_q) * 32'(LANES) + 32'(k_q);
  assign in_rng = idx < 32'(IN_LEN);

  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) sum = sum + 32'(prod_q[k]);
  end

  // M is an unsigned scale; the low 64 bits of the product are exact for signed s.
  always_comb begin
    s     = acc_q - z_q + b_q;
    p     = 64'(s) * {32'b0, m_q};
    hi    = p[63:32];
    rnd   = p[31] & (|p[30:0]);
    r     = 34'(hi) + 34'(OUT_ZP) + 34'(rnd);
    lo    = relu_q ? 34'(OUT_ZP) : -34'sd128;
    res_d = r[7:0];
    if (r > 34'sd127)  res_d = 8'sd127;
    else if (r < lo)   res_d = lo[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        a_q[k]    <= '0;
        wt_q[k]   <= '0;
        prod_q[k] <= '0;
      end
      acc_q  <= '0;
      m_q    <= '0;
      z_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      relu_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      en_q <= act_en;
      if (state_q == S_IDLE && start) relu_q <= relu_en;
      // Lane data arrives one cycle after its request; disabled lanes pad with zero.
      if ((state_q == S_FETCH && k_q != '0) || state_q == S_DRAIN) begin
        for (int k = 0; k < LANES - 1; k++) begin
          a_q[k]  <= a_q[k+1];
          wt_q[k] <= wt_q[k+1];
        end
        a_q[LANES-1]  <= en_q ? act_data : '0;
        wt_q[LANES-1] <= en_q ? w_data : '0;
      end
      if (state_q == S_MUL)
        for (int k = 0; k < LANES; k++) prod_q[k] <= a_q[k] * wt_q[k];
      if (acc_clr)               acc_q <= '0;
      else if (state_q == S_ACC) acc_q <= acc_q + sum;
      if (state_q == S_QP && k_q == KW'(1)) m_q <= qp_data;
      if (state_q == S_QP && k_q == KW'(2)) z_q <= qp_data;
      if (state_q == S_QDRAIN)              b_q <= qp_data;
      if (state_q == S_REQ)                 res_q <= res_d;
    end
  end

  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign act_en   = (state_q == S_FETCH) && in_rng;
  assign w_en     = act_en;
  assign act_addr = act_en ? ACT_AW'(idx) : '0;
  assign w_addr   = w_en ? W_AW'(32'(W_BASE) + 32'(o_q) * 32'(IN_LEN) + idx) : '0;
  assign qp_en    = state_q == S_QP;
  assign qp_addr  = qp_en ? QP_AW'(32'(QP_BASE) + 32'(o_q) * 32'd3 + 32'(k_q)) : '0;
  assign res_we   = state_q == S_WR;
  assign res_addr = res_we ? OW'(o_q) : '0;
  assign res_data = res_we ? res_q : '0;
endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine: directed runs push expected writes, a monitor checks them.
module tb_fc_layer_engine;
  localparam int IN_LEN = 5, OUT_LEN = 3, LANES = 4, ACT_AW = 4, W_AW = 6, QP_AW = 4;
  localparam int W_BASE = 8, QP_BASE = 2, OUT_ZP = 0;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic busy, done, act_en, w_en, qp_en, res_we;
  logic [ACT_AW-1:0] act_addr;
  logic [W_AW-1:0]   w_addr;
  logic [QP_AW-1:0]  qp_addr;
  logic [1:0]        res_addr;
  logic signed [7:0]  act_data, w_data, res_data;
  logic signed [31:0] qp_data;

  logic signed [7:0] act_mem [16];
  logic signed [7:0] w_mem [64];
  logic [31:0]       qp_mem [16];

  int exp_a[$], exp_d[$];
  int checks = 0, passes = 0;
  int done_cnt = 0, act_cnt = 0, w_cnt = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .ACT_AW(ACT_AW), .W_AW(W_AW),
    .QP_AW(QP_AW), .W_BASE(W_BASE), .QP_BASE(QP_BASE), .OUT_ZP(OUT_ZP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .act_en(act_en), .act_addr(act_addr), .act_data(act_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .qp_en(qp_en), .qp_addr(qp_addr), .qp_data(qp_data),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  // ROMs with one-cycle latency; disabled reads return garbage.
  always @(posedge clk) begin
    act_data <= act_en ? act_mem[act_addr] : 8'($urandom);
    w_data   <= w_en ? w_mem[w_addr] : 8'($urandom);
    qp_data  <= qp_en ? qp_mem[qp_addr] : $urandom;
  end

  task automatic chk(input string nm, input longint got, input longint req);
    checks++;
    if (got == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", nm, got, req);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (act_en) act_cnt++;
    if (w_en) w_cnt++;
    if (res_we) begin
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write", res_addr, res_data);
      end else begin
        chk("wr_addr", res_addr, exp_a.pop_front());
        chk("wr_data", res_data, exp_d.pop_front());
      end
    end
  end

  task automatic expect3(input int d0, input int d1, input int d2);
    exp_a.push_back(0); exp_d.push_back(d0);
    exp_a.push_back(1); exp_d.push_back(d1);
    exp_a.push_back(2); exp_d.push_back(d2);
  endtask

  task automatic set_act(input int v0, input int v1, input int v2, input int v3, input int v4);
    act_mem[0] = 8'(v0); act_mem[1] = 8'(v1); act_mem[2] = 8'(v2);
    act_mem[3] = 8'(v3); act_mem[4] = 8'(v4);
  endtask

  task automatic set_w(input int o, input int v0, input int v1, input int v2, input int v3, input int v4);
    w_mem[W_BASE + o*IN_LEN + 0] = 8'(v0); w_mem[W_BASE + o*IN_LEN + 1] = 8'(v1);
    w_mem[W_BASE + o*IN_LEN + 2] = 8'(v2); w_mem[W_BASE + o*IN_LEN + 3] = 8'(v3);
    w_mem[W_BASE + o*IN_LEN + 4] = 8'(v4);
  endtask

  task automatic set_qp(input int o, input logic [31:0] m, input int z, input int b);
    qp_mem[QP_BASE + 3*o + 0] = m;
    qp_mem[QP_BASE + 3*o + 1] = 32'(z);
    qp_mem[QP_BASE + 3*o + 2] = 32'(b);
  endtask

  task automatic t1_setup();
    set_act(1, 1, 1, 1, 1);
    for (int o = 0; o < OUT_LEN; o++) begin
      set_w(o, 2, 2, 2, 2, 2);
      set_qp(o, 32'h8000_0000, 0, 0);
    end
  endtask

  task automatic run(input string nm, input logic r, input bit inject);
    int cyc, d0, a0, w0;
    d0 = done_cnt; a0 = act_cnt; w0 = w_cnt;
    @(negedge clk); start = 1'b1; relu_en = r;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      start = inject && (cyc == 20 || cyc == 45);
      if (cyc == 10) chk({nm, "_busy_mid"}, busy, 1);
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, cyc, 61);
    @(negedge clk); @(negedge clk);
    chk({nm, "_pending_writes"}, exp_a.size(), 0);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_act_reads"}, act_cnt - a0, OUT_LEN * IN_LEN);
    chk({nm, "_w_reads"}, w_cnt - w0, OUT_LEN * IN_LEN);
    chk({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < 16; i++) begin act_mem[i] = 8'sd9; qp_mem[i] = '0; end
    for (int i = 0; i < 64; i++) w_mem[i] = 8'sd9;
    #12;
    chk("rst_ctrl", {busy, done, act_en, w_en, qp_en, res_we}, 0);
    chk("rst_addr", {act_addr, w_addr, qp_addr, res_addr}, 0);
    chk("rst_res_data", res_data, 0);
    @(negedge clk); rst_n = 1'b1;

    t1_setup(); expect3(5, 5, 5); run("t1", 1'b0, 1'b0);

    for (int o = 0; o < OUT_LEN; o++) set_qp(o, 32'h8000_0000, 0, -40);
    expect3(-15, -15, -15); run("t2", 1'b0, 1'b0);
    expect3(0, 0, 0);       run("t2_relu", 1'b1, 1'b0);

    set_qp(0, 32'h7FFF_FFFF, 0, 300);
    set_qp(1, 32'h7FFF_FFFF, 0, -1000);
    set_qp(2, 32'h7FFF_FFFF, 0, 0);
    expect3(127, -128, 5); run("t3_sat", 1'b0, 1'b0);

    set_qp(0, 32'h4000_0000, 7, 0);
    set_qp(1, 32'h8000_0000, 9, 0);
    set_qp(2, 32'h8000_0000, 11, 0);
    expect3(1, 0, -1); run("t4_round", 1'b0, 1'b0);

    set_act(1, 2, 3, 4, 5);
    set_w(0, 1, 1, 1, 1, 1);
    set_w(1, -1, 2, -3, 4, -5);
    set_w(2, 5, 4, 3, 2, 1);
    for (int o = 0; o < OUT_LEN; o++) set_qp(o, 32'h8000_0000, 0, 0);
    expect3(7, -8, 17); run("t5_dot", 1'b0, 1'b0);

    set_act(-128, 127, 0, 0, -128);
    set_w(0, -128, 127, 0, 0, -128);
    set_w(1, 127, -128, 0, 0, 0);
    set_w(2, 0, 0, 0, 0, 0);
    set_qp(0, 32'h8000_0000, 48800, 0);
    set_qp(1, 32'h0100_0000, 0, 0);
    set_qp(2, 32'h8000_0000, 0, 77);
    expect3(48, -127, 38); run("t5_extreme", 1'b0, 1'b0);

    t1_setup(); expect3(5, 5, 5); run("t6_restart_ignored", 1'b0, 1'b1);

    @(negedge clk); start = 1'b1; relu_en = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_in_fetch", act_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_abort_ctrl", {busy, done, act_en, w_en, qp_en, res_we}, 0);
    chk("t6_abort_addr", {act_addr, w_addr, qp_addr, res_addr}, 0);
    chk("t6_abort_res_data", res_data, 0);
    @(negedge clk); rst_n = 1'b1;
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    chk("t6_abort_no_done", done_cnt - d0, 0);
    chk("t6_abort_idle", busy, 0);

    expect3(5, 5, 5); run("t6_after_abort", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
